// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports, optional
// write-to-read bypass and a load-use busy scoreboard driving Stall.
module reg_file #(
    parameter bit BYPASS     = 1'b1,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_LOG2-1:0] RsAddr,
    input  logic [DEPTH_LOG2-1:0] RtAddr,
    input  logic                  RsUsed,
    input  logic                  RtUsed,
    output logic [31:0]           RsData,
    output logic [31:0]           RtData,
    input  logic                  WrEn,
    input  logic [DEPTH_LOG2-1:0] WrAddr,
    input  logic [31:0]           WrData,
    input  logic                  LdIssue,
    input  logic [DEPTH_LOG2-1:0] LdAddr,
    output logic                  Stall
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]      regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             wr_fire, ld_fire;
    logic             rs_hit, rt_hit, rs_res, rt_res, rs_stall, rt_stall;

    assign wr_fire = WrEn && (WrAddr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_fire) begin
            regs_q[WrAddr] <= WrData;
        end
    end

    // Bypass hits only on a real (non-zero) write, so r0 can never forward.
    assign rs_hit = BYPASS && wr_fire && (WrAddr == RsAddr);
    assign rt_hit = BYPASS && wr_fire && (WrAddr == RtAddr);

    assign RsData = (!rst_n || RsAddr == '0) ? '0 : (rs_hit ? WrData : regs_q[RsAddr]);
    assign RtData = (!rst_n || RtAddr == '0) ? '0 : (rt_hit ? WrData : regs_q[RtAddr]);

    assign rs_res   = BYPASS && WrEn && (WrAddr == RsAddr);
    assign rt_res   = BYPASS && WrEn && (WrAddr == RtAddr);
    assign rs_stall = RsUsed && busy_q[RsAddr] && !rs_res;
    assign rt_stall = RtUsed && busy_q[RtAddr] && !rt_res;
    assign Stall    = rst_n && (rs_stall || rt_stall);

    // A stalled instruction never leaves ID, so its load must not mark busy.
    assign ld_fire = LdIssue && !Stall && (LdAddr != '0);

    always_comb begin
        busy_d = busy_q;
        if (WrEn)    busy_d[WrAddr] = 1'b0;
        if (ld_fire) busy_d[LdAddr] = 1'b1;   // younger load wins over clear
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: BYPASS=1 and BYPASS=0 instances share stimulus and are
// checked against an array/scoreboard model of the register-file rules.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  RsAddr, RtAddr, WrAddr, LdAddr;
    logic        RsUsed, RtUsed, WrEn, LdIssue;
    logic [31:0] WrData;
    logic [31:0] rs1, rt1, rs0, rt0;
    logic        st1, st0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    bit   [31:0] m_busy [2];

    always #5 clk = ~clk;

    reg_file #(.BYPASS(1'b1), .DEPTH_LOG2(5)) u_bp1 (
        .clk(clk), .rst_n(rst_n), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RsUsed(RsUsed), .RtUsed(RtUsed), .RsData(rs1), .RtData(rt1),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .LdIssue(LdIssue), .LdAddr(LdAddr), .Stall(st1));

    reg_file #(.BYPASS(1'b0), .DEPTH_LOG2(5)) u_bp0 (
        .clk(clk), .rst_n(rst_n), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RsUsed(RsUsed), .RtUsed(RtUsed), .RsData(rs0), .RtData(rt0),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .LdIssue(LdIssue), .LdAddr(LdAddr), .Stall(st0));

    function automatic logic [31:0] exp_rd(input int bp, input logic [4:0] a);
        if (!rst_n || a == 0) return 32'h0;
        if (bp == 1 && WrEn && WrAddr == a) return WrData;
        return m_mem[a];
    endfunction

    function automatic logic exp_stall(input int bp);
        bit rs_wait, rt_wait;
        if (!rst_n) return 1'b0;
        rs_wait = RsUsed && RsAddr != 0 && m_busy[bp][RsAddr] &&
                  !(bp == 1 && WrEn && WrAddr == RsAddr);
        rt_wait = RtUsed && RtAddr != 0 && m_busy[bp][RtAddr] &&
                  !(bp == 1 && WrEn && WrAddr == RtAddr);
        return rs_wait || rt_wait;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            m_busy[0] = '0;
            m_busy[1] = '0;
        end else begin
            for (int bp = 0; bp < 2; bp++) begin
                bit s;
                s = exp_stall(bp);
                if (WrEn) m_busy[bp][WrAddr] = 1'b0;
                if (LdIssue && !s && LdAddr != 0) m_busy[bp][LdAddr] = 1'b1;
            end
            if (WrEn && WrAddr != 0) m_mem[WrAddr] = WrData;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WrEn = 0; LdIssue = 0; RsUsed = 0; RtUsed = 0;
        RsAddr = 0; RtAddr = 0; WrAddr = 0; LdAddr = 0; WrData = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        WrEn = 1; WrAddr = 5; WrData = 32'h11111111;
        LdIssue = 1; LdAddr = 6; RsAddr = 5; RtAddr = 6; RtUsed = 1;
        #1;
        checks++;
        if ({rs1, rt1, st1, rs0, rt0, st0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %b %h %h %b need all 0", rs1, rt1, st1, rs0, rt0, st0);
        end
        tick(); tick();
        rst_n = 1; WrEn = 0; LdIssue = 0;
        #1;
        checks++;
        if ({rs1, rt1, st1, rs0, rt0, st0} !== '0) begin
            errors++;
            $display("FAIL reset_ignored_wr_ld got %h %h %b %h %h %b need all 0", rs1, rt1, st1, rs0, rt0, st0);
        end
        tick();
    endtask

    task automatic test_write_read();
        idle(); WrEn = 1; WrAddr = 5; WrData = 32'hDEADBEEF; RsAddr = 5;
        #1;
        checks++;
        if (rs1 !== 32'hDEADBEEF || rs0 !== 32'h0) begin
            errors++;
            $display("FAIL write_cycle_read got bp1=%h bp0=%h need DEADBEEF 00000000", rs1, rs0);
        end
        tick();
        WrEn = 0;
        #1;
        checks++;
        if (rs1 !== 32'hDEADBEEF || rs0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_after_write got bp1=%h bp0=%h need DEADBEEF", rs1, rs0);
        end
    endtask

    task automatic test_r0();
        idle(); WrEn = 1; WrAddr = 0; WrData = 32'h12345678;
        #1;
        checks++;
        if ({rs1, rt1, rs0, rt0} !== '0) begin
            errors++;
            $display("FAIL r0_write_cycle got %h %h %h %h need 0", rs1, rt1, rs0, rt0);
        end
        tick(); WrEn = 0; tick();
        checks++;
        if ({rs1, rt1, rs0, rt0} !== '0) begin
            errors++;
            $display("FAIL r0_later got %h %h %h %h need 0", rs1, rt1, rs0, rt0);
        end
    endtask

    task automatic test_load_use();
        idle(); LdIssue = 1; LdAddr = 8;
        tick();
        LdIssue = 0; RsAddr = 8; RsUsed = 1;
        #1;
        checks++;
        if (st1 !== 1'b1 || st0 !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got bp1=%b bp0=%b need 1 1", st1, st0);
        end
        tick();
        WrEn = 1; WrAddr = 8; WrData = 32'hCAFE0008;
        #1;
        checks++;
        if (st1 !== 1'b0 || st0 !== 1'b1) begin
            errors++;
            $display("FAIL load_use_resolve got bp1=%b bp0=%b need 0 1", st1, st0);
        end
        tick();
        WrEn = 0;
        #1;
        checks++;
        if (st1 !== 1'b0 || st0 !== 1'b0 || rs0 !== 32'hCAFE0008) begin
            errors++;
            $display("FAIL load_use_after got st=%b %b rs0=%h need 0 0 CAFE0008", st1, st0, rs0);
        end
        tick();
    endtask

    task automatic test_same_edge();
        idle(); LdIssue = 1; LdAddr = 9; WrEn = 1; WrAddr = 9; WrData = 32'h9;
        tick();
        idle(); RtAddr = 9; RtUsed = 1;
        #1;
        checks++;
        if (st1 !== 1'b1 || st0 !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear got bp1=%b bp0=%b need 1 1", st1, st0);
        end
        WrEn = 1; WrAddr = 9; WrData = 32'h99; RtUsed = 0;
        tick(); idle(); tick();
    endtask

    task automatic test_dual_bypass();
        idle(); RsAddr = 3; RtAddr = 3; WrEn = 1; WrAddr = 3; WrData = 32'hA5A5A5A5;
        #1;
        checks++;
        if (rs1 !== 32'hA5A5A5A5 || rt1 !== 32'hA5A5A5A5 || rs0 !== 32'h0 || rt0 !== 32'h0) begin
            errors++;
            $display("FAIL dual_bypass got %h %h %h %h need A5A5A5A5 x2, 0 x2", rs1, rt1, rs0, rt0);
        end
        tick();
    endtask

    task automatic test_ld_while_stalled();
        idle(); LdIssue = 1; LdAddr = 10;
        tick();
        RsAddr = 10; RsUsed = 1; LdAddr = 11;
        tick();
        idle(); RtAddr = 11; RtUsed = 1;
        #1;
        checks++;
        if (st1 !== 1'b0 || st0 !== 1'b0) begin
            errors++;
            $display("FAIL stalled_load_ignored got bp1=%b bp0=%b need 0 0", st1, st0);
        end
        WrEn = 1; WrAddr = 10; WrData = 32'h10;
        tick(); idle(); tick();
    endtask

    task automatic test_multi_busy();
        idle(); LdIssue = 1; LdAddr = 12;
        tick();
        LdAddr = 13;
        tick();
        idle(); RsAddr = 12; RsUsed = 1; WrEn = 1; WrAddr = 13; WrData = 32'h13;
        #1;
        checks++;
        if (st1 !== 1'b1 || st0 !== 1'b1) begin
            errors++;
            $display("FAIL multi_busy_hold got bp1=%b bp0=%b need 1 1", st1, st0);
        end
        tick();
        WrAddr = 12; WrData = 32'h12;
        tick(); idle(); tick();
    endtask

    task automatic test_reset_mid();
        idle(); WrEn = 1; WrAddr = 4; WrData = 32'h44444444; LdIssue = 1; LdAddr = 4;
        tick();
        idle(); rst_n = 0;
        tick();
        rst_n = 1; RsAddr = 4; RsUsed = 1; RtAddr = 5;
        #1;
        checks++;
        if ({rs1, rt1, st1, rs0, rt0, st0} !== '0) begin
            errors++;
            $display("FAIL reset_mid got %h %h %b %h %h %b need all 0", rs1, rt1, st1, rs0, rt0, st0);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [129:0] exp_v;
            rst_n   = ($urandom_range(0, 59) != 0);
            RsAddr  = 5'($urandom_range(0, 15));
            RtAddr  = 5'($urandom_range(0, 15));
            RsUsed  = 1'($urandom);
            RtUsed  = 1'($urandom);
            WrEn    = ($urandom_range(0, 1) == 0);
            WrAddr  = 5'($urandom_range(0, 15));
            WrData  = $urandom;
            LdIssue = ($urandom_range(0, 2) == 0);
            LdAddr  = 5'($urandom_range(0, 15));
            #1;
            exp_v = {exp_rd(1, RsAddr), exp_rd(1, RtAddr), exp_stall(1),
                     exp_rd(0, RsAddr), exp_rd(0, RtAddr), exp_stall(0)};
            checks++;
            if ({rs1, rt1, st1, rs0, rt0, st0} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] got %h need %h", n, {rs1, rt1, st1, rs0, rt0, st0}, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_busy[0] = '0;
        m_busy[1] = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_load_use();
        test_same_edge();
        test_dual_bypass();
        test_ld_while_stalled();
        test_multi_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter BYPASS, default 1, enables the same-cycle write-to-read bypass when 1.
REQ-002 Parameter DEPTH_LOG2, default 5, gives the address width; the block SHALL have 2**DEPTH_LOG2 entries (32 at default).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  synchronous reset, active-low, sampled on the clk rising edge.
REQ-005 RsAddr  in  5  read port A address, taken from instruction bits 25-21.
REQ-006 RtAddr  in  5  read port B address, taken from instruction bits 20-16.
REQ-007 RsUsed / RtUsed  in  1 each  the current instruction consumes port A / port B.
REQ-008 RsData / RtData  out  32 each  read data for port A / port B.
REQ-009 WrEn  in  1  write-back enable from the WB stage.
REQ-010 WrAddr  in  5  write-back destination, driven by the rt/rd destination-select mux (after the WB pipeline register).
REQ-011 WrData  in  32  write-back data.
REQ-012 LdIssue  in  1  a load leaves ID this cycle.
REQ-013 LdAddr  in  5  destination register of that load.
REQ-014 Stall  out  1  load-use hazard; the ID stage holds while Stall=1.

Function
REQ-015 Storage SHALL be 32 x 32-bit registers.
- Register 0 SHALL always read 0x00000000.
- Writes to register 0 SHALL be ignored.
REQ-016 A write SHALL occur at the clk rising edge when rst_n=1, WrEn=1 and WrAddr!=0.
REQ-017 Reads SHALL be combinational, with zero-cycle latency from the address to the data output.
REQ-018 With BYPASS=1, when WrEn=1, WrAddr!=0 and WrAddr equals a read address:
- that port SHALL output WrData in the same cycle.
- Both ports SHALL bypass independently, including when RsAddr=RtAddr.
REQ-019 With BYPASS=0, a read SHALL return the stored value.
- A read of the address being written SHALL return the pre-write value.
REQ-020 Scoreboard busy[31:1] SHALL be set at the clk edge when LdIssue=1 and LdAddr!=0.
- busy[0] SHALL be constant 0.
REQ-021 busy[n] SHALL clear at the clk edge when WrEn=1 and WrAddr=n.
REQ-022 Same-edge set and clear of one register: set SHALL win, because the new load is younger.
REQ-023 Stall SHALL be combinational and asserted when either holds:
- RsUsed=1, busy[RsAddr]=1, and the stall is not resolved this cycle;
- RtUsed=1, busy[RtAddr]=1, and the stall is not resolved this cycle.
REQ-024 "Resolved this cycle" SHALL mean all of the following:
- BYPASS=1;
- WrEn=1;
- WrAddr equals the busy address.
REQ-025 When BYPASS=0, a busy read register SHALL stall until the cycle after its clearing write.
REQ-026 Reads of address 0 SHALL never stall.
REQ-027 LdIssue SHALL be ignored in any cycle where Stall=1.
- The stalled instruction is not issued, so no busy bit SHALL be set for it.
REQ-028 Several outstanding loads to different registers SHALL each hold their own busy bit.

Reset
REQ-029 At a clk edge with rst_n=0:
- all 32 registers SHALL clear to 0x00000000;
- all busy bits SHALL clear.
REQ-030 While rst_n=0:
- WrEn and LdIssue SHALL be ignored;
- RsData, RtData and Stall SHALL be driven 0.
REQ-031 Reset asserted mid-operation SHALL discard pending busy bits.
- Stall SHALL be 0 in the first cycle after rst_n returns to 1.
REQ-032 No state SHALL change without a clk edge; reset is not asynchronous.

Verification
REQ-033 Write WrAddr=5, WrData=0xDEADBEEF, WrEn=1 -> RsAddr=5 reads 0xDEADBEEF next cycle; with BYPASS=1 it also reads 0xDEADBEEF in the write cycle.
REQ-034 Write WrAddr=0, WrData=0x12345678 -> RsAddr=0 and RtAddr=0 read 0x00000000 in the write cycle and in every later cycle.
REQ-035 LdIssue=1, LdAddr=8, then next cycle RsAddr=8, RsUsed=1, WrEn=0 -> Stall=1; the cycle WrEn=1 and WrAddr=8 -> Stall=0 with BYPASS=1, or Stall=0 one cycle later with BYPASS=0.
REQ-036 Same edge LdIssue=1, LdAddr=9 and WrEn=1, WrAddr=9 -> busy[9] stays set; the next read of 9 with RtUsed=1 gives Stall=1.
REQ-037 RsAddr=RtAddr=3, WrEn=1, WrAddr=3, WrData=0xA5A5A5A5, BYPASS=1 -> RsData=RtData=0xA5A5A5A5.
REQ-038 Registers loaded and busy[4] set, then rst_n=0 for one edge -> all reads 0x00000000; RsAddr=4 with RsUsed=1 gives Stall=0.
